// File: rtl/phys_free_list.sv
// phys_free_list: physical register tag free list for the rename/dispatch stage.
// Hands out up to N_WAY free tags per cycle and takes tags back from ROB retirement
// (old tags) and from a taken-branch flush (every squashed tag). Availability is kept
// as a bit vector together with a registered free counter.
// Optional illegal-free checker: define PHYS_FREE_LIST_CHECK_EN to build it; otherwise
// o_fl_error is tied low and the checking logic is absent.
// Port i_reset is asynchronous and active-low.

`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef N_ROB
`define N_ROB 8
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif
`ifndef SD
`define SD
`endif

module phys_free_list #(
  parameter int N_WAY  = `N_WAY,
  parameter int N_ROB  = `N_ROB,
  parameter int TAG_W  = `CDB_BITS,
  parameter int N_PHYS = 2**TAG_W,
  parameter int N_ARCH = 32,
  localparam int CNT_W  = $clog2(N_PHYS) + 1,
  localparam int SLOT_W = $clog2(N_WAY) + 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_WAY-1:0]         i_dispatch_req,
  output logic [N_WAY*TAG_W-1:0]   o_alloc_tag,
  output logic [N_WAY-1:0]         o_alloc_valid,
  input  logic [N_WAY-1:0]         i_retire_valid,
  input  logic [N_WAY*TAG_W-1:0]   i_retire_told,
  input  logic                     i_branch_haz,
  input  logic [N_ROB*TAG_W-1:0]   i_free_list_haz,
  output logic [CNT_W-1:0]         o_free_count,
  output logic [SLOT_W-1:0]        o_free_slots,
  output logic                     o_fl_error
);

  // All returns (retire ways first, then flush slots) are handled as one flat list.
  localparam int N_RET = N_WAY + N_ROB;

  // Tags N_ARCH..N_PHYS-1 start free; tag 0 ("no tag") is never free.
  function automatic logic [N_PHYS-1:0] resetFreeBits();
    logic [N_PHYS-1:0] v;
    v = '0;
    for (int t = 1; t < N_PHYS; t++) begin
      if (t >= N_ARCH) begin
        v[t] = 1'b1;
      end
    end
    return v;
  endfunction

  localparam logic [N_PHYS-1:0] RESET_BITS  = resetFreeBits();
  localparam logic [CNT_W-1:0]  RESET_COUNT = CNT_W'(N_PHYS - N_ARCH);

  logic [N_PHYS-1:0] r_free_bits;
  logic [CNT_W-1:0]  r_count;

  logic [TAG_W-1:0]  w_offer_tag [N_WAY];
  logic [N_WAY-1:0]  w_consume;
  logic [N_PHYS-1:0] w_clear_mask;
  logic [CNT_W-1:0]  w_n_consumed;
  logic [TAG_W-1:0]  w_ret_tag [N_RET];
  logic [N_RET-1:0]  w_ret_en;
  logic [N_PHYS-1:0] w_set_mask;
  logic [N_PHYS-1:0] w_kept_bits;
  logic [N_PHYS-1:0] w_newly_set;
  logic [CNT_W-1:0]  w_n_newly_set;
  logic [N_PHYS-1:0] w_free_bits_next;
  logic [CNT_W-1:0]  w_count_next;

  // Way k is offered the k-th lowest free tag, computed from registered state only
  always_comb begin
    logic [N_PHYS-1:0] w_scan;
    logic              w_found;
    w_scan    = r_free_bits;
    w_scan[0] = 1'b0;
    for (int k = 0; k < N_WAY; k++) begin
      w_offer_tag[k] = '0;
      w_found        = 1'b0;
      for (int t = 0; t < N_PHYS; t++) begin
        if (!w_found && w_scan[t]) begin
          w_found        = 1'b1;
          w_offer_tag[k] = TAG_W'(t);
          w_scan[t]      = 1'b0;
        end
      end
    end
  end

  // Way k is valid only while more than k tags are free, so empty offers nothing
  always_comb begin
    o_alloc_tag   = '0;
    o_alloc_valid = '0;
    for (int k = 0; k < N_WAY; k++) begin
      o_alloc_valid[k]              = (r_count > CNT_W'(k));
      o_alloc_tag[k*TAG_W +: TAG_W] = w_offer_tag[k];
    end
  end

  // Dispatch stall hint: the free count saturated at the machine width
  always_comb begin
    o_free_slots = SLOT_W'(r_count);
    if (r_count >= CNT_W'(N_WAY)) begin
      o_free_slots = SLOT_W'(N_WAY);
    end
  end

  assign o_free_count = r_count;

  // Each way independently consumes its own offered tag; requests on invalid ways drop
  always_comb begin
    w_consume    = i_dispatch_req & o_alloc_valid;
    w_clear_mask = '0;
    w_n_consumed = '0;
    for (int k = 0; k < N_WAY; k++) begin
      if (w_consume[k]) begin
        w_clear_mask[w_offer_tag[k]] = 1'b1;
        w_n_consumed                 = w_n_consumed + CNT_W'(1);
      end
    end
  end

  // Collect retire and flush returns into one list; tag 0 marks an empty slot
  always_comb begin
    for (int k = 0; k < N_WAY; k++) begin
      w_ret_tag[k] = i_retire_told[k*TAG_W +: TAG_W];
      w_ret_en[k]  = i_retire_valid[k] && (w_ret_tag[k] != '0);
    end
    for (int i = 0; i < N_ROB; i++) begin
      w_ret_tag[N_WAY+i] = i_free_list_haz[i*TAG_W +: TAG_W];
      w_ret_en[N_WAY+i]  = i_branch_haz && (w_ret_tag[N_WAY+i] != '0);
    end
  end

  // Clear consumed bits, then set returned ones so a same-cycle return wins
  always_comb begin
    w_set_mask = '0;
    for (int r = 0; r < N_RET; r++) begin
      if (w_ret_en[r]) begin
        w_set_mask[w_ret_tag[r]] = 1'b1;
      end
    end
    w_kept_bits      = r_free_bits & ~w_clear_mask;
    w_newly_set      = w_set_mask & ~w_kept_bits;
    w_free_bits_next = w_kept_bits | w_set_mask;
  end

  // Count only bits that actually flip to free, so double-frees never inflate the count
  always_comb begin
    w_n_newly_set = '0;
    for (int t = 0; t < N_PHYS; t++) begin
      if (w_newly_set[t]) begin
        w_n_newly_set = w_n_newly_set + CNT_W'(1);
      end
    end
    w_count_next = r_count - w_n_consumed + w_n_newly_set;
  end

  // Free vector and counter registers; reset discards everything in flight
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_free_bits <= RESET_BITS;
      r_count     <= RESET_COUNT;
    end else begin
      r_free_bits <= `SD w_free_bits_next;
      r_count     <= `SD w_count_next;
    end
  end

`ifdef PHYS_FREE_LIST_CHECK_EN
  logic [N_PHYS-1:0] r_ever_alloc;
  logic              r_fl_error;
  logic              w_illegal;

  // A return is illegal if the tag is already free (which includes a tag consumed this
  // cycle), repeats another return this cycle, or is an architectural tag that was never
  // handed out by this list (its reset mapping does not count as an allocation)
  always_comb begin
    logic [N_PHYS-1:0] w_seen;
    w_seen    = '0;
    w_illegal = 1'b0;
    for (int r = 0; r < N_RET; r++) begin
      if (w_ret_en[r]) begin
        if (r_free_bits[w_ret_tag[r]] || w_clear_mask[w_ret_tag[r]] || w_seen[w_ret_tag[r]]) begin
          w_illegal = 1'b1;
        end
        if ((int'(w_ret_tag[r]) < N_ARCH) && !r_ever_alloc[w_ret_tag[r]]) begin
          w_illegal = 1'b1;
        end
        w_seen[w_ret_tag[r]] = 1'b1;
      end
    end
  end

  // Remember every tag ever handed out and hold the error flag until reset
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_ever_alloc <= '0;
      r_fl_error   <= 1'b0;
    end else begin
      r_ever_alloc <= `SD (r_ever_alloc | w_clear_mask);
      if (w_illegal) begin
        r_fl_error <= `SD 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // Simulation message for each cycle that carries an illegal return
  always_ff @(posedge i_clock) begin
    if (i_reset && w_illegal) begin
      $error("phys_free_list: illegal free-list return");
    end
  end
`endif

  assign o_fl_error = r_fl_error;
`else
  assign o_fl_error = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// tb_phys_free_list: self-checking bench for phys_free_list (N_WAY=2, TAG_W=6, N_ARCH=32).
// A behavioural model (an array of free flags, offers found by scanning in tag order)
// predicts every output; directed tables and sequences add hand-derived constants.
// Follows PHYS_FREE_LIST_CHECK_EN when the same macro is defined for the bench.

module tb_phys_free_list;

  localparam int N_WAY  = 2;
  localparam int N_ROB  = 4;
  localparam int TAG_W  = 6;
  localparam int N_PHYS = 64;
  localparam int N_ARCH = 32;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic [N_WAY-1:0]       dispatchReq = '0;
  logic [N_WAY*TAG_W-1:0] allocTag;
  logic [N_WAY-1:0]       allocValid;
  logic [N_WAY-1:0]       retireValid = '0;
  logic [N_WAY*TAG_W-1:0] retireTold = '0;
  logic                   branchHaz = 1'b0;
  logic [N_ROB*TAG_W-1:0] freeListHaz = '0;
  logic [6:0]             freeCount;
  logic [1:0]             freeSlots;
  logic                   flError;

  phys_free_list #(
    .N_WAY(N_WAY), .N_ROB(N_ROB), .TAG_W(TAG_W), .N_PHYS(N_PHYS), .N_ARCH(N_ARCH)
  ) dut (
    .i_clock(clock),
    .i_reset(reset),
    .i_dispatch_req(dispatchReq),
    .o_alloc_tag(allocTag),
    .o_alloc_valid(allocValid),
    .i_retire_valid(retireValid),
    .i_retire_told(retireTold),
    .i_branch_haz(branchHaz),
    .i_free_list_haz(freeListHaz),
    .o_free_count(freeCount),
    .o_free_slots(freeSlots),
    .o_fl_error(flError)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int testsRun = 0;
  int failures = 0;
  int illegalReturns = 0;

  bit mFree [N_PHYS];
  bit mEver [N_PHYS];
  bit mErr;

  typedef struct {
    logic [1:0] req;
    logic [1:0] rv;
    int         told0;
    int         told1;
    logic       bh;
    int         h0, h1, h2, h3;
    int         expCount;
    logic [1:0] expValid;
    int         expTag0;
    int         expTag1;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mkVec(input logic [1:0] req, input logic [1:0] rv,
                                 input int told0, input int told1, input logic bh,
                                 input int h0, input int h1, input int h2, input int h3,
                                 input int expCount, input logic [1:0] expValid,
                                 input int expTag0, input int expTag1);
    vec_t v;
    v.req = req; v.rv = rv; v.told0 = told0; v.told1 = told1; v.bh = bh;
    v.h0 = h0; v.h1 = h1; v.h2 = h2; v.h3 = h3;
    v.expCount = expCount; v.expValid = expValid; v.expTag0 = expTag0; v.expTag1 = expTag1;
    return v;
  endfunction

  function automatic int modelCount();
    int c = 0;
    for (int t = 1; t < N_PHYS; t++) if (mFree[t]) c++;
    return c;
  endfunction

  function automatic int modelNthFree(input int n);
    int seen = 0;
    for (int t = 1; t < N_PHYS; t++) begin
      if (mFree[t]) begin
        if (seen == n) return t;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic void modelReset();
    for (int t = 0; t < N_PHYS; t++) begin
      mFree[t] = (t >= N_ARCH);
      mEver[t] = 1'b0;
    end
    mErr = 1'b0;
  endfunction

  // One clock of the free list: hand out the lowest free tags, then take returns back
  function automatic void modelStep(input logic [1:0] req, input logic [1:0] rv,
                                    input int told0, input int told1, input logic bh,
                                    input int h0, input int h1, input int h2, input int h3);
    int  cons[$];
    int  rets[$];
    int  hz[4];
    int  cnt;
    bit  err;
    cnt = modelCount();
    for (int k = 0; k < 2; k++) if (req[k] && cnt > k) cons.push_back(modelNthFree(k));
    if (rv[0] && told0 != 0) rets.push_back(told0);
    if (rv[1] && told1 != 0) rets.push_back(told1);
    hz[0] = h0; hz[1] = h1; hz[2] = h2; hz[3] = h3;
    if (bh) for (int i = 0; i < 4; i++) if (hz[i] != 0) rets.push_back(hz[i]);
    err = 1'b0;
    for (int i = 0; i < rets.size(); i++) begin
      if (mFree[rets[i]]) err = 1'b1;
      for (int j = 0; j < i; j++) if (rets[j] == rets[i]) err = 1'b1;
      if (rets[i] < N_ARCH && !mEver[rets[i]]) err = 1'b1;
    end
    foreach (cons[i]) begin
      mFree[cons[i]] = 1'b0;
      mEver[cons[i]] = 1'b1;
    end
    foreach (rets[i]) mFree[rets[i]] = 1'b1;
    if (err) illegalReturns++;
`ifdef PHYS_FREE_LIST_CHECK_EN
    mErr = mErr | err;
`endif
  endfunction

  function automatic int pickTag();
    int busy[$];
    for (int t = 1; t < N_PHYS; t++) if (!mFree[t]) busy.push_back(t);
    if (busy.size() > 0 && $urandom_range(0, 3) != 0)
      return busy[$urandom_range(0, busy.size() - 1)];
    return int'($urandom_range(0, N_PHYS - 1));
  endfunction

  task automatic compare(input string what, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", what, actual, expected);
    end
  endtask

  // Compare every DUT output against the behavioural model
  task automatic checkOutput(input string ctx);
    int cnt;
    cnt = modelCount();
    compare($sformatf("%s valid0", ctx), int'(allocValid[0]), int'(cnt > 0));
    compare($sformatf("%s valid1", ctx), int'(allocValid[1]), int'(cnt > 1));
    if (cnt > 0) compare($sformatf("%s tag0", ctx), int'(allocTag[5:0]), modelNthFree(0));
    if (cnt > 1) compare($sformatf("%s tag1", ctx), int'(allocTag[11:6]), modelNthFree(1));
    compare($sformatf("%s count", ctx), int'(freeCount), cnt);
    compare($sformatf("%s slots", ctx), int'(freeSlots), (cnt > 2) ? 2 : cnt);
    compare($sformatf("%s fl_error", ctx), int'(flError), int'(mErr));
  endtask

  // Drive one cycle of inputs, advance the model, and land 1 unit past the clock edge
  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] rv,
                               input int told0, input int told1, input logic bh,
                               input int h0, input int h1, input int h2, input int h3);
    dispatchReq = req;
    retireValid = rv;
    retireTold  = {6'(told1), 6'(told0)};
    branchHaz   = bh;
    freeListHaz = {6'(h3), 6'(h2), 6'(h1), 6'(h0)};
    modelStep(req, rv, told0, told1, bh, h0, h1, h2, h3);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    @(negedge clock);
    dispatchReq = '0; retireValid = '0; retireTold = '0; branchHaz = 1'b0; freeListHaz = '0;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("in reset");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0] = mkVec(2'b11, 2'b00,  0,  0, 1'b0,  0, 0,  0, 0, 0, 2'b00,  0,  0);
    vecs[1] = mkVec(2'b00, 2'b11, 40,  5, 1'b0,  0, 0,  0, 0, 2, 2'b11,  5, 40);
    vecs[2] = mkVec(2'b00, 2'b01, 33,  0, 1'b1, 34, 0, 35, 0, 5, 2'b11,  5, 33);
    vecs[3] = mkVec(2'b01, 2'b01, 45,  0, 1'b0,  0, 0,  0, 0, 5, 2'b11, 33, 34);
    vecs[4] = mkVec(2'b10, 2'b00,  0,  0, 1'b0,  0, 0,  0, 0, 4, 2'b11, 33, 35);
    vecs[5] = mkVec(2'b01, 2'b01, 33,  0, 1'b0,  0, 0,  0, 0, 4, 2'b11, 33, 35);
    vecs[6] = mkVec(2'b00, 2'b10,  0, 40, 1'b0,  0, 0,  0, 0, 4, 2'b11, 33, 35);
    vecs[7] = mkVec(2'b00, 2'b11, 20, 20, 1'b0,  0, 0,  0, 0, 5, 2'b11, 20, 33);
    vecs[8] = mkVec(2'b00, 2'b11,  0,  0, 1'b1,  0, 0,  0, 0, 5, 2'b11, 20, 33);
    vecs[9] = mkVec(2'b11, 2'b00,  0,  0, 1'b0,  0, 0,  0, 0, 3, 2'b11, 35, 40);

    doReset();
    compare("reset tag0", int'(allocTag[5:0]), 32);
    compare("reset tag1", int'(allocTag[11:6]), 33);
    compare("reset valid", int'(allocValid), 3);
    compare("reset count", int'(freeCount), 32);
    compare("reset slots", int'(freeSlots), 2);
    compare("reset fl_error", int'(flError), 0);
    checkOutput("after reset");

    for (int i = 0; i < 16; i++) begin
      compare($sformatf("drain%0d tag0", i), int'(allocTag[5:0]), 32 + 2 * i);
      compare($sformatf("drain%0d tag1", i), int'(allocTag[11:6]), 33 + 2 * i);
      applyStimulus(2'b11, 2'b00, 0, 0, 1'b0, 0, 0, 0, 0);
      checkOutput($sformatf("drain%0d", i));
    end
    compare("drained count", int'(freeCount), 0);
    compare("drained valid", int'(allocValid), 0);
    compare("drained slots", int'(freeSlots), 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].rv, vecs[i].told0, vecs[i].told1, vecs[i].bh,
                    vecs[i].h0, vecs[i].h1, vecs[i].h2, vecs[i].h3);
      checkOutput($sformatf("vec%0d", i));
      compare($sformatf("vec%0d const count", i), int'(freeCount), vecs[i].expCount);
      compare($sformatf("vec%0d const valid", i), int'(allocValid), int'(vecs[i].expValid));
      if (vecs[i].expValid[0])
        compare($sformatf("vec%0d const tag0", i), int'(allocTag[5:0]), vecs[i].expTag0);
      if (vecs[i].expValid[1])
        compare($sformatf("vec%0d const tag1", i), int'(allocTag[11:6]), vecs[i].expTag1);
    end

    // Reset in the middle of a cycle carrying allocations and returns
    dispatchReq = 2'b11; retireValid = 2'b11; retireTold = {6'd2, 6'd1};
    branchHaz = 1'b1; freeListHaz = {6'd7, 6'd6, 6'd5, 6'd4};
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("mid-cycle reset");
    compare("mid-cycle reset count", int'(freeCount), 32);
    dispatchReq = '0; retireValid = '0; retireTold = '0; branchHaz = 1'b0; freeListHaz = '0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("after mid-cycle reset");
    compare("after mid-cycle reset count", int'(freeCount), 32);

    // Fill the list completely by returning every architectural tag
    doReset();
    for (int i = 0; i < 15; i++) applyStimulus(2'b00, 2'b11, 2 * i + 1, 2 * i + 2, 1'b0, 0, 0, 0, 0);
    applyStimulus(2'b00, 2'b01, 31, 0, 1'b0, 0, 0, 0, 0);
    checkOutput("full");
    compare("full count", int'(freeCount), 63);
    compare("full tag0", int'(allocTag[5:0]), 1);
    applyStimulus(2'b00, 2'b11, 63, 1, 1'b1, 40, 0, 2, 0);
    checkOutput("full double-free");
    compare("full double-free count", int'(freeCount), 63);

    // Double-free of an already free tag and the sticky error flag
    doReset();
    applyStimulus(2'b00, 2'b01, 50, 0, 1'b0, 0, 0, 0, 0);
    checkOutput("double-free 50");
`ifdef PHYS_FREE_LIST_CHECK_EN
    compare("fl_error rises", int'(flError), 1);
`else
    compare("fl_error tied low", int'(flError), 0);
`endif
    compare("double-free 50 count", int'(freeCount), 32);
    applyStimulus(2'b01, 2'b00, 0, 0, 1'b0, 0, 0, 0, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 1'b0, 0, 0, 0, 0);
    checkOutput("fl_error hold");
    doReset();
    compare("fl_error cleared", int'(flError), 0);

    // Randomized traffic against the model
    doReset();
    for (int i = 0; i < 400; i++) begin
      logic [1:0] req;
      logic [1:0] rv;
      logic       bh;
      int         hz[4];
      req = 2'($urandom_range(0, 3));
      rv  = 2'($urandom_range(0, 3));
      if (i < 150) rv = rv & 2'($urandom_range(0, 3));
      bh  = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < 4; j++) hz[j] = ($urandom_range(0, 1) == 1) ? pickTag() : 0;
      applyStimulus(req, rv, pickTag(), pickTag(), bh, hz[0], hz[1], hz[2], hz[3]);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("[TB] info: %0d illegal returns exercised", illegalReturns);
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/phys_free_list.md
# phys_free_list

- Allocates free physical register tags to the dispatch stage, up to `N_WAY` per cycle.
- Reclaims tags from the ROB in two ways:
  - old tags (`retire_told`) of retiring instructions;
  - every tag of a squashed ROB (`free_list_haz`) on a taken-branch flush.
- Tracks availability as a bit vector plus a registered free counter.
- Sits between the ROB retire/flush outputs and the rename/dispatch stage.

## Interface
- `N_WAY`, default `` `N_WAY ``: superscalar width (allocation and retire ports).
- `N_ROB`, default `` `N_ROB ``: ROB depth; width of the flush return vector.
- `TAG_W`, default `` `CDB_BITS ``: physical tag width.
- `N_PHYS`, default `2**TAG_W`: number of physical registers.
- `N_ARCH`, default 32: tags `0..N_ARCH-1` are architecturally mapped at reset.
- `clock` in, 1: rising-edge clock.
- `reset` in, 1: asynchronous, active-low reset.
- `dispatch_req` in, `N_WAY`: way k requests one tag this cycle.
- `alloc_tag` out, `N_WAY`×`TAG_W`: tag offered to way k.
- `alloc_valid` out, `N_WAY`: `alloc_tag[k]` is valid.
- `retire_valid` in, `N_WAY`: ROB retire strobe per way.
- `retire_told` in, `N_WAY`×`TAG_W`: old tag freed by a retiring instruction.
- `branch_haz` in, 1: ROB flush this cycle.
- `free_list_haz` in, `N_ROB`×`TAG_W`: squashed tags; 0 means empty slot.
- `free_count` out, `clog2(N_PHYS)+1`: number of free tags, registered.
- `free_slots` out, `clog2(N_WAY)+1`: `min(free_count, N_WAY)`, used by dispatch stall.
- `fl_error` out, 1: sticky illegal-free flag (see Configuration).

## Operation
- State:
  - `free_bits[N_PHYS]`, where bit t = 1 means tag t is free;
  - `count` register.
- Tag 0 is reserved as "no tag". It is never allocated, and returns of 0 are ignored.
- Offer:
  - `alloc_tag[k]` is the k-th lowest set bit of `free_bits`.
  - `alloc_valid[k] = (count > k)`.
  - Offers depend only on registered state; there is no combinational path from any input.
- Consume: way k removes `alloc_tag[k]` when `dispatch_req[k] & alloc_valid[k]`.
  - Ways are independent. For example, `dispatch_req=2'b10` consumes only the 2nd-lowest tag.
  - A request with `alloc_valid[k]=0` is dropped. Dispatch must gate requests using `free_slots`.
- Retire return: for each k with `retire_valid[k]` and `retire_told[k]!=0`, set bit `retire_told[k]`.
- Flush return: when `branch_haz=1`, set the bit of every nonzero `free_list_haz[i]`.
  - This is processed in the same cycle as any retire returns.
- Flush does not block allocation. Upstream suppresses `dispatch_req` during flush when required.
- Next-state order within a cycle:
  1. clear consumed bits;
  2. then set returned bits (a return wins on the same tag);
  3. `count_next = count - consumed + newly_set`, where a bit already free is not counted twice.

## Timing
- Reset (async, `reset`=0):
  - `free_bits[t]=1` for `N_ARCH ≤ t < N_PHYS`, else 0;
  - `count = N_PHYS-N_ARCH`;
  - `fl_error=0`.
  - Outputs reflect this immediately; reset asserted mid-cycle discards all in-flight returns and allocations.
- Update latency:
  - `free_bits`, `count` and `fl_error` update on the rising edge, with `` `SD `` delay.
  - A tag returned in cycle n is offerable in cycle n+1. There is no bypass.
  - A tag consumed in cycle n is absent from offers in cycle n+1.
- Empty (`count=0`): all `alloc_valid=0`, `free_slots=0`; returns still accepted.
- Full: every non-reserved tag free implies `count=N_PHYS-1`; further returns are double-frees.
- `free_slots` saturates at `N_WAY`.

## Configuration
- `PHYS_FREE_LIST_CHECK_EN` defined:
  - `fl_error` is set and held until reset on any of these:
    - a return of a tag that is already free;
    - a return of a tag consumed in the same cycle;
    - two identical returns in one cycle;
    - a return of a tag `< N_ARCH` before that tag was ever allocated.
  - A simulation `$error` message is also printed.
- Undefined: `fl_error` is tied to 0 and the checking logic is absent. Functional behaviour is otherwise identical.

## Test plan
All scenarios use `N_WAY=2`, `TAG_W=6`, `N_ARCH=32`.
- Reset: release reset and check offers, counts and error flag.
  - Required: `alloc_tag={33,32}`, `alloc_valid=2'b11`, `free_count=32`, `free_slots=2`, `fl_error=0`.
- Allocation: `dispatch_req=2'b11` for 16 cycles.
  - Required: the tags drain 32..63 in order, `free_count` ends at 0, then `alloc_valid=0` and `free_slots=0`.
- Retire return: from empty, retire `{retire_valid=2'b11, retire_told={5,40}}`.
  - Required: next cycle `free_count=2`, `alloc_tag={40,5}`.
- Flush: `branch_haz=1` with `free_list_haz` holding tags 34, 0, 35, 0.
  - Required: `free_count` increases by 2 and the zero slots are ignored.
  - Simultaneous `retire_told=33` is also freed, for a total of +3.
- Same-cycle allocate and free: `dispatch_req=2'b01` while returning tag 45.
  - Required: the lowest tag is consumed, 45 appears next cycle, and the count is unchanged.
- Checks (with `PHYS_FREE_LIST_CHECK_EN`): return tag 50 while it is already free.
  - Required: `fl_error` rises on the next edge and stays high until `reset` goes low.
